fetch_queue: RTL and testbench

- Parametrised next-generation instruction fetch stage.
- It issues sequential requests to the instruction cache and buffers the returned instructions in a DEPTH-entry prefetch queue. It then feeds decode one {pc, inst} pair per cycle.
- Redirects (jal/branch) flush the queue and discard the in-flight response. Stalls freeze the decode output but do not stop prefetch.
- Sits between the I-cache port and the decode stage, replacing the single-entry fetch stage.

---
 rtl/fetch_queue.sv | 144 ++++++++++++++
 tb/tb_fetch_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues sequential I-cache requests, buffers responses in a
// DEPTH-entry circular prefetch queue and presents one {pc, inst} pair per cycle to decode.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP      = XLEN'(32'h00000013)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cache_ack,
    input  logic [XLEN-1:0]        inst,
    output logic                   addr_ready,
    output logic [XLEN-1:0]        addr,
    input  logic                   stall,
    input  logic                   jal,
    input  logic                   branch,
    input  logic [XLEN-1:0]        j_target,
    input  logic [XLEN-1:0]        b_target,
    output logic [XLEN-1:0]        final_pc,
    output logic [XLEN-1:0]        final_inst,
    output logic                   final_valid,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_outstanding;
    logic            r_discard;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic [XLEN-1:0] r_q_inst [DEPTH];
    logic [XLEN-1:0] r_final_pc;
    logic [XLEN-1:0] r_final_inst;
    logic            r_final_valid;

    logic            w_redir;
    logic [XLEN-1:0] w_target;
    logic            w_issue;
    logic            w_ack;
    logic            w_push;
    logic            w_pop;

    always_comb begin
        w_redir  = jal | branch;
        w_target = jal ? j_target : b_target;
        // Issue only while no request is in flight, so count+outstanding reduces to count.
        w_issue  = !rst && !r_outstanding && !w_redir && (r_count < CW'(DEPTH));
        w_ack    = cache_ack && r_outstanding;
        w_push   = w_ack && !r_discard && !w_redir;
        w_pop    = !w_redir && !stall && (r_count != '0);
    end

    assign addr_ready  = w_issue;
    assign addr        = w_issue ? r_fetch_pc : '0;
    assign final_pc    = r_final_pc;
    assign final_inst  = r_final_inst;
    assign final_valid = r_final_valid;
    assign q_count     = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= '0;
            r_outstanding <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            if (w_redir) begin
                r_fetch_pc <= w_target;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            if (w_issue) begin
                r_req_pc      <= r_fetch_pc;
                r_outstanding <= 1'b1;
            end else if (w_ack) begin
                r_outstanding <= 1'b0;
            end
            // The response to a request flushed by a redirect must be dropped when it lands.
            if (w_ack) begin
                r_discard <= 1'b0;
            end else if (w_redir && r_outstanding) begin
                r_discard <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_redir) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]   <= r_req_pc;
            r_q_inst[r_wr_ptr] <= inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_final_pc    <= RESET_PC - XLEN'(4);
            r_final_inst  <= NOP;
            r_final_valid <= 1'b0;
        end else if (w_redir) begin
            r_final_inst  <= NOP;
            r_final_valid <= 1'b0;
        end else if (stall) begin
            r_final_valid <= r_final_valid;
        end else if (r_count != '0) begin
            r_final_pc    <= r_q_pc[r_rd_ptr];
            r_final_inst  <= r_q_inst[r_rd_ptr];
            r_final_valid <= 1'b1;
        end else begin
            r_final_inst  <= NOP;
            r_final_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: sequential fetch, stall fill, redirects and reset mid-request.
module tb_fetch_queue;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOPI  = 32'h00000013;
    localparam logic [31:0] IBASE = 32'h00100093;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cache_ack = 1'b0;
    logic [XLEN-1:0] inst = '0;
    logic            addr_ready;
    logic [XLEN-1:0] addr;
    logic            stall = 1'b0;
    logic            jal = 1'b0;
    logic            branch = 1'b0;
    logic [XLEN-1:0] j_target = '0;
    logic [XLEN-1:0] b_target = '0;
    logic [XLEN-1:0] final_pc;
    logic [XLEN-1:0] final_inst;
    logic            final_valid;
    logic [CW-1:0]   q_count;

    int              n_checks = 0;
    int              n_errors = 0;
    int              cyc = 0;
    int              n_stall_ack = 0;
    logic            track = 1'b0;
    logic            auto_ack = 1'b0;
    logic            watch_dead = 1'b0;
    logic [XLEN-1:0] exp_addr = '0;
    logic [XLEN-1:0] exp_pc = '0;

    fetch_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0),
        .NOP      (NOPI)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .cache_ack   (cache_ack),
        .inst        (inst),
        .addr_ready  (addr_ready),
        .addr        (addr),
        .stall       (stall),
        .jal         (jal),
        .branch      (branch),
        .j_target    (j_target),
        .b_target    (b_target),
        .final_pc    (final_pc),
        .final_inst  (final_inst),
        .final_valid (final_valid),
        .q_count     (q_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One clock: record any request, optionally answer it next cycle with IBASE+pc,
    // and check each freshly popped decode entry against the expected sequence.
    task automatic tick();
        logic            req;
        logic [XLEN-1:0] ra;
        logic            was_stall;
        #1;
        req       = addr_ready;
        ra        = addr;
        was_stall = stall;
        if (stall && cache_ack) n_stall_ack++;
        if (req && track) begin
            check_eq("addr_seq", ra, exp_addr);
            exp_addr += 4;
        end
        @(posedge clk);
        #1;
        cyc++;
        cache_ack = 1'b0;
        inst      = '0;
        if (req && auto_ack) begin
            cache_ack = 1'b1;
            inst      = IBASE + ra;
        end
        #1;
        if (track && final_valid && !was_stall) begin
            check_eq("pop_pc", final_pc, exp_pc);
            check_eq("pop_inst", final_inst, IBASE + exp_pc);
            exp_pc += 4;
        end
        if (watch_dead) check_eq("no_dead", {31'b0, final_inst == 32'hDEAD}, 32'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_final_pc", final_pc, 32'hFFFF_FFFC);
        check_eq("rst_final_inst", final_inst, NOPI);
        check_eq("rst_final_valid", {31'b0, final_valid}, 32'h0);
        check_eq("rst_addr_ready", {31'b0, addr_ready}, 32'h0);
        check_eq("rst_addr", addr, 32'h0);
        check_eq("rst_q_count", {{(32-CW){1'b0}}, q_count}, 32'h0);

        // Sequential fetch with 1-cycle ack.
        rst = 1'b0; track = 1'b1; auto_ack = 1'b1; exp_addr = 0; exp_pc = 0; cyc = 0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (cyc == 2) check_eq("seq_not_yet_valid", {31'b0, final_valid}, 32'h0);
            if (cyc == 3) check_eq("seq_first_valid", {31'b0, final_valid}, 32'h1);
        end

        // Stall: queue fills with four entries, decode output frozen on pc 0x14.
        stall = 1'b1; n_stall_ack = 0;
        repeat (20) tick();
        check_eq("stall_pushes", n_stall_ack, 32'd4);
        check_eq("stall_q_count", {{(32-CW){1'b0}}, q_count}, 32'd4);
        check_eq("stall_addr_ready", {31'b0, addr_ready}, 32'h0);
        check_eq("stall_final_pc", final_pc, 32'h14);
        check_eq("stall_final_inst", final_inst, IBASE + 32'h14);
        check_eq("stall_final_valid", {31'b0, final_valid}, 32'h1);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("release_nogap", {31'b0, final_valid}, 32'h1);
        end
        repeat (4) tick();

        // Redirect with request to 0x10 outstanding.
        track = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; exp_addr = 0; exp_pc = 0; track = 1'b1;
        repeat (8) tick();
        check_eq("pre_redir_addr", addr, 32'h10);
        auto_ack = 1'b0; track = 1'b0;
        tick();
        jal = 1'b1; j_target = 32'h200; watch_dead = 1'b1;
        #1 check_eq("redir_no_issue", {31'b0, addr_ready}, 32'h0);
        tick();
        jal = 1'b0;
        #1 check_eq("redir_bubble", {31'b0, final_valid}, 32'h0);
        check_eq("redir_flush", {{(32-CW){1'b0}}, q_count}, 32'h0);
        check_eq("discard_wait", {31'b0, addr_ready}, 32'h0);
        tick();
        cache_ack = 1'b1; inst = 32'hDEAD;
        #1 check_eq("discard_wait2", {31'b0, addr_ready}, 32'h0);
        tick();
        check_eq("dead_not_pushed", {{(32-CW){1'b0}}, q_count}, 32'h0);
        check_eq("redir_addr_ready", {31'b0, addr_ready}, 32'h1);
        check_eq("redir_addr", addr, 32'h200);
        exp_addr = 32'h200; exp_pc = 32'h200; auto_ack = 1'b1; track = 1'b1;
        repeat (4) tick();
        watch_dead = 1'b0;
        check_eq("redir_final_pc", final_pc, 32'h200);

        // Branch coincident with ack.
        auto_ack = 1'b0;
        tick();
        track = 1'b0;
        cache_ack = 1'b1; inst = 32'h1234_5678; branch = 1'b1; b_target = 32'h80;
        #1 check_eq("br_no_issue", {31'b0, addr_ready}, 32'h0);
        tick();
        branch = 1'b0;
        #1 check_eq("br_addr_ready", {31'b0, addr_ready}, 32'h1);
        check_eq("br_addr", addr, 32'h80);
        check_eq("br_q_count", {{(32-CW){1'b0}}, q_count}, 32'h0);
        check_eq("br_final_valid", {31'b0, final_valid}, 32'h0);
        check_eq("br_final_pc_held", final_pc, 32'h204);

        // Simultaneous jal and branch: jal wins.
        jal = 1'b1; branch = 1'b1; j_target = 32'h40; b_target = 32'h90;
        #1 check_eq("both_no_issue", {31'b0, addr_ready}, 32'h0);
        tick();
        jal = 1'b0; branch = 1'b0;
        #1 check_eq("both_bubble", {31'b0, final_valid}, 32'h0);
        check_eq("both_addr_ready", {31'b0, addr_ready}, 32'h1);
        check_eq("both_addr", addr, 32'h40);
        exp_addr = 32'h40; exp_pc = 32'h40; auto_ack = 1'b1; track = 1'b1;
        repeat (6) tick();

        // Reset while a request is outstanding, then a stale ack.
        auto_ack = 1'b0;
        tick();
        track = 1'b0;
        rst = 1'b1;
        #1 check_eq("mrst_addr_ready", {31'b0, addr_ready}, 32'h0);
        check_eq("mrst_final_pc", final_pc, 32'hFFFF_FFFC);
        check_eq("mrst_final_inst", final_inst, NOPI);
        check_eq("mrst_final_valid", {31'b0, final_valid}, 32'h0);
        check_eq("mrst_q_count", {{(32-CW){1'b0}}, q_count}, 32'h0);
        tick();
        rst = 1'b0; cache_ack = 1'b1; inst = 32'hBAD;
        #1 check_eq("mrst_issue", {31'b0, addr_ready}, 32'h1);
        check_eq("mrst_issue_addr", addr, 32'h0);
        tick();
        check_eq("stale_ignored", {{(32-CW){1'b0}}, q_count}, 32'h0);
        check_eq("stale_final_pc", final_pc, 32'hFFFF_FFFC);
        check_eq("stale_final_inst", final_inst, NOPI);
        check_eq("stale_final_valid", {31'b0, final_valid}, 32'h0);
        cache_ack = 1'b1; inst = IBASE;
        tick();
        check_eq("mrst_push", {{(32-CW){1'b0}}, q_count}, 32'h1);
        check_eq("mrst_hold_pc", final_pc, 32'hFFFF_FFFC);
        check_eq("mrst_hold_inst", final_inst, NOPI);
        tick();
        check_eq("mrst_first_pc", final_pc, 32'h0);
        check_eq("mrst_first_inst", final_inst, IBASE);
        check_eq("mrst_first_valid", {31'b0, final_valid}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
